wide_sub_sequencer: RTL and testbench

//  Multi-cycle controller that computes a WIDTH-bit subtraction D = X - Y - Bin on one SLICE_W-bit

---
 rtl/sub_seq_pkg.sv | 20 ++
 rtl/wide_sub_sequencer_nsubtractor.sv | 22 ++
 rtl/wide_sub_sequencer.sv | 142 ++++++++++++++
 tb/tb_wide_sub_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sub_seq_pkg.sv
// Shared definitions for the slice-serial subtractor: FSM encoding and
// the sizing helpers derived from the operand and slice widths.
package sub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nslice_f(input int width, input int slice_w);
    return width / slice_w;
  endfunction

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_sub_sequencer_nsubtractor.sv
// Combinational N-bit subtractor slice with borrow in/out: D = A - B - Bin.
module NSubtractor #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_A,
  input  logic [N-1:0] i_B,
  input  logic         i_Bin,
  output logic [N-1:0] o_D,
  output logic         o_Bout
);

  logic [N:0] diff_s;

  // One extra bit catches the borrow as the sign of the widened difference.
  always_comb begin
    diff_s = {1'b0, i_A} - {1'b0, i_B} - {{N{1'b0}}, i_Bin};
  end

  assign o_D    = diff_s[N-1:0];
  assign o_Bout = diff_s[N];

endmodule

// File: rtl/wide_sub_sequencer.sv
// Slice-serial WIDTH-bit subtractor: one SLICE_W-bit slice per clock, LS slice
// first, with valid/ready handshakes on the command and result sides.
module wide_sub_sequencer
  import sub_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start_Valid,
  output logic             o_Start_Ready,
  input  logic [WIDTH-1:0] i_X,
  input  logic [WIDTH-1:0] i_Y,
  input  logic             i_Bin,
  output logic             o_Done_Valid,
  input  logic             i_Done_Ready,
  output logic [WIDTH-1:0] o_D,
  output logic             o_Bout,
  output logic             o_V,
  output logic             o_Z,
  output logic             o_Busy
);

  localparam int NSLICE = nslice_f(WIDTH, SLICE_W);
  localparam int CW     = cnt_width_f(NSLICE);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $fatal(1, "wide_sub_sequencer: WIDTH must be a non-zero multiple of SLICE_W");
  end

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   x_q, y_q, res_q;
  logic [WIDTH-1:0]   d_q;
  logic               bout_q, v_q, z_q;
  logic               ready_q, valid_q, busy_q;

  logic [SLICE_W-1:0]       slice_d_s;
  logic                     slice_bout_s;
  logic [WIDTH+SLICE_W-1:0] cat_s;
  logic [WIDTH-1:0]         res_d;
  logic                     last_d;
  logic                     v_d;

  NSubtractor #(.N(SLICE_W)) u_slice (
    .i_A    (x_q[SLICE_W-1:0]),
    .i_B    (y_q[SLICE_W-1:0]),
    .i_Bin  (borrow_q),
    .o_D    (slice_d_s),
    .o_Bout (slice_bout_s)
  );

  // New slice enters the result from the top; on the last slice the operand
  // shift regs still hold the original sign bits in their low slice.
  always_comb begin
    cat_s  = {slice_d_s, res_q};
    res_d  = cat_s[WIDTH+SLICE_W-1:SLICE_W];
    last_d = (cnt_q == CW'(NSLICE - 1));
    v_d    = (x_q[SLICE_W-1] != y_q[SLICE_W-1]) && (res_d[WIDTH-1] == y_q[SLICE_W-1]);
  end

  // Sequencer FSM, slice datapath and registered result/handshake outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      borrow_q <= 1'b0;
      x_q      <= {WIDTH{1'b0}};
      y_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      d_q      <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_Start_Valid) begin
            state_q  <= ST_RUN;
            x_q      <= i_X;
            y_q      <= i_Y;
            borrow_q <= i_Bin;
            cnt_q    <= {CW{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          x_q      <= x_q >> SLICE_W;
          y_q      <= y_q >> SLICE_W;
          borrow_q <= slice_bout_s;
          res_q    <= res_d;
          if (last_d) begin
            state_q <= ST_DONE;
            cnt_q   <= {CW{1'b0}};
            d_q     <= res_d;
            bout_q  <= slice_bout_s;
            v_q     <= v_d;
            z_q     <= (res_d == {WIDTH{1'b0}});
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          // A start arriving with the release waits for the following IDLE cycle.
          if (i_Done_Ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_Start_Ready = ready_q;
  assign o_Done_Valid  = valid_q;
  assign o_Busy        = busy_q;
  assign o_D           = d_q;
  assign o_Bout        = bout_q;
  assign o_V           = v_q;
  assign o_Z           = z_q;

endmodule

// File: tb/tb_wide_sub_sequencer.sv
// Randomized self-checking bench for wide_sub_sequencer against an
// arithmetic reference of D = X - Y - Bin with flags and handshake timing.
module tb_wide_sub_sequencer;

  localparam int WIDTH   = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = WIDTH / SLICE_W;

  logic             clk;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] x_in, y_in;
  logic             bin_in;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] d_out;
  logic             bout_out, v_out, z_out, busy_out;

  int n_checks;
  int n_fail;

  logic [WIDTH-1:0] exp_d;
  logic             exp_b, exp_v, exp_z;

  wide_sub_sequencer #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Start_Valid (start_valid),
    .o_Start_Ready (start_ready),
    .i_X           (x_in),
    .i_Y           (y_in),
    .i_Bin         (bin_in),
    .o_Done_Valid  (done_valid),
    .i_Done_Ready  (done_ready),
    .o_D           (d_out),
    .o_Bout        (bout_out),
    .o_V           (v_out),
    .o_Z           (z_out),
    .o_Busy        (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic b);
    logic [WIDTH:0] full;
    full  = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, b};
    exp_d = full[WIDTH-1:0];
    exp_b = full[WIDTH];
    exp_v = (x[WIDTH-1] != y[WIDTH-1]) && (exp_d[WIDTH-1] == y[WIDTH-1]);
    exp_z = (exp_d == {WIDTH{1'b0}});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    check_val({tag, ".D"},    64'(d_out),    64'(exp_d));
    check_val({tag, ".Bout"}, 64'(bout_out), 64'(exp_b));
    check_val({tag, ".V"},    64'(v_out),    64'(exp_v));
    check_val({tag, ".Z"},    64'(z_out),    64'(exp_z));
  endtask

  // Present a command in IDLE; afterwards inputs are scrambled to prove they were latched.
  task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic b);
    check_val("ready_before_start", 64'(start_ready), 64'd1);
    model(x, y, b);
    x_in = x; y_in = y; bin_in = b; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    x_in = $urandom; y_in = $urandom; bin_in = 1'($urandom);
    check_val("busy_after_accept", 64'(busy_out), 64'd1);
    check_val("ready_after_accept", 64'(start_ready), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 1;
    while (!done_valid && lat < 4 * NSLICE + 8) begin
      start_valid = 1'(($urandom & 32'd3) == 32'd0);
      tick();
      if (!done_valid) lat++;
    end
    start_valid = 1'b0;
    check_val({tag, ".latency"}, 64'(lat), 64'(NSLICE));
    check_result(tag);
  endtask

  task automatic release_done(input string tag, input int hold, input bit pulse_start);
    for (int i = 0; i < hold; i++) begin
      start_valid = pulse_start ? 1'(i % 2) : 1'b0;
      tick();
      check_val({tag, ".hold_valid"}, 64'(done_valid), 64'd1);
      check_val({tag, ".hold_ready"}, 64'(start_ready), 64'd0);
      check_result({tag, ".hold"});
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check_val({tag, ".valid_drop"}, 64'(done_valid), 64'd0);
    check_val({tag, ".idle_busy"}, 64'(busy_out), 64'd0);
    check_result({tag, ".after"});
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic b, input int hold);
    start_op(x, y, b);
    wait_done(tag);
    release_done(tag, hold, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    start_valid = 1'b0; done_ready = 1'b0;
    x_in = '0; y_in = '0; bin_in = 1'b0;
    rst_n = 1'b0;
    #12;
    check_val("rst.ready", 64'(start_ready), 64'd1);
    check_val("rst.valid", 64'(done_valid), 64'd0);
    check_val("rst.busy",  64'(busy_out), 64'd0);
    check_val("rst.D",     64'(d_out), 64'd0);
    check_val("rst.flags", 64'({bout_out, v_out, z_out}), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("t1", 32'h0000_0100, 32'h0000_0001, 1'b0, 0);
    run_op("t2", 32'h0000_0000, 32'h0000_0001, 1'b0, 1);
    run_op("t3a", 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
    run_op("t3b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2);
    run_op("t4a", 32'h1234_5678, 32'h1234_5678, 1'b0, 0);
    run_op("t4b", 32'h1234_5678, 32'h1234_5678, 1'b1, 0);

    // Long hold with start pulses, then release together with a new start.
    start_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    wait_done("t5");
    release_done("t5", 10, 1'b1);
    check_val("t5.idle_ready", 64'(start_ready), 64'd1);
    run_op("t5n", 32'h0000_0005, 32'h0000_0007, 1'b0, 0);

    start_op(32'h0000_0001, 32'h0000_0002, 1'b0);
    wait_done("t5c");
    x_in = 32'h0000_1000; y_in = 32'h0000_0FFF; bin_in = 1'b0;
    start_valid = 1'b1; done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    check_val("t5c.idle_after_release", 64'(start_ready), 64'd1);
    check_val("t5c.not_accepted", 64'(busy_out), 64'd0);
    check_result("t5c.kept");
    model(32'h0000_1000, 32'h0000_0FFF, 1'b0);
    tick();
    start_valid = 1'b0;
    check_val("t5c.accepted", 64'(busy_out), 64'd1);
    wait_done("t5d");
    release_done("t5d", 0, 1'b0);

    // Reset in the middle of RUN abandons the operation.
    start_op(32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check_val("t6.busy", 64'(busy_out), 64'd0);
    check_val("t6.valid", 64'(done_valid), 64'd0);
    check_val("t6.ready", 64'(start_ready), 64'd1);
    check_val("t6.D", 64'(d_out), 64'd0);
    check_val("t6.flags", 64'({bout_out, v_out, z_out}), 64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check_val("t6.no_result", 64'(done_valid), 64'd0);
    run_op("t6r", 32'h0000_0100, 32'h0000_0001, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      logic [WIDTH-1:0] rx, ry;
      rx = $urandom;
      ry = (k % 5 == 0) ? rx : WIDTH'($urandom);
      run_op("rnd", rx, ry, 1'($urandom), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
